// File: rtl/regfile_writeback_queue_pkg.sv
// Shared types and constants for the register-file writeback queue.
package regfile_writeback_queue_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 64;
  localparam int NUM_REGS = 32;

  // Hardwired-zero register; only honoured when the queue is built with ZERO_REG_EN=1.
  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(31);

  // One queued result as seen by the forwarding search.
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
    logic              valid;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_queue_if.sv
// Bundle of producer handshake, register-file write port, read-port snoop and occupancy.
interface regfile_writeback_queue_if
  import regfile_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4
) ();

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rd;
  logic [DATA_W-1:0] in_data;
  logic              wb_hold;
  logic              reg_write;
  logic [ADDR_W-1:0] write_register;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] read_register_1;
  logic [ADDR_W-1:0] read_register_2;
  logic              fwd_hit_1;
  logic [DATA_W-1:0] fwd_data_1;
  logic              fwd_hit_2;
  logic [DATA_W-1:0] fwd_data_2;
  logic [CNT_W-1:0]  count;

  // Pipeline side: produces results, holds writeback, issues read addresses.
  modport master (
    output in_valid, in_rd, in_data, wb_hold, read_register_1, read_register_2,
    input  in_ready, reg_write, write_register, write_data,
           fwd_hit_1, fwd_data_1, fwd_hit_2, fwd_data_2, count
  );

  // Queue side.
  modport slave (
    input  in_valid, in_rd, in_data, wb_hold, read_register_1, read_register_2,
    output in_ready, reg_write, write_register, write_data,
           fwd_hit_1, fwd_data_1, fwd_hit_2, fwd_data_2, count
  );

endinterface

// File: rtl/regfile_fwd_match.sv
// Youngest-match search over the occupied queue slots for one read address.
module regfile_fwd_match
  import regfile_writeback_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  wb_entry_t [DEPTH-1:0] entries_i,
  input  logic [PTR_W-1:0]      head_i,
  input  logic [CNT_W-1:0]      count_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic                  hit_o,
  output logic [DATA_W-1:0]     data_o
);

  logic [PTR_W-1:0] idx;

  // Walk from head (oldest) toward tail; a later match overrides, so the youngest wins.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = head_i;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + PTR_W'(i);
      if ((CNT_W'(i) < count_i) && entries_i[idx].valid && (entries_i[idx].rd == raddr_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// In-order writeback FIFO feeding the register file's single write port, with read bypass.
module regfile_writeback_queue
  import regfile_writeback_queue_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter bit ZERO_REG_EN = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  regfile_writeback_queue_if.slave  wbq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DEPTH-1:0]  vld_q;
  logic [ADDR_W-1:0] rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  wb_entry_t [DEPTH-1:0] entries;
  logic                  push;
  logic                  store;
  logic                  pop;
  logic                  not_empty;

  // Handshake, drain and occupancy decode; writes to the zero register complete but are dropped.
  always_comb begin
    not_empty = (count_q != '0);
    wbq.in_ready = (count_q < CNT_W'(DEPTH));
    push  = wbq.in_valid && wbq.in_ready;
    store = push && !(ZERO_REG_EN && (wbq.in_rd == ZERO_REG));
    wbq.reg_write      = not_empty && !wbq.wb_hold;
    pop                = wbq.reg_write;
    wbq.write_register = not_empty ? rd_q[head_q]   : '0;
    wbq.write_data     = not_empty ? data_q[head_q] : '0;
    wbq.count          = count_q;
  end

  // Next-state for pointers and occupancy; push and pop together leave count unchanged.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (store) tail_d = tail_q + PTR_W'(1);
    if (pop)   head_d = head_q + PTR_W'(1);
    case ({store, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers and occupancy, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry-valid bits; store and pop never hit the same slot because the queue is neither empty nor full then.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      if (pop)   vld_q[head_q] <= 1'b0;
      if (store) vld_q[tail_q] <= 1'b1;
    end
  end

  // Entry payload; not reset since it is only observed through the valid bits and count.
  always_ff @(posedge clk) begin
    if (store) begin
      rd_q[tail_q]   <= wbq.in_rd;
      data_q[tail_q] <= wbq.in_data;
    end
  end

  // Present the slots as structs for the forwarding search.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i] = '{rd: rd_q[i], data: data_q[i], valid: vld_q[i]};
    end
  end

  regfile_fwd_match #(.DEPTH(DEPTH)) u_fwd_1 (
    .entries_i (entries),
    .head_i    (head_q),
    .count_i   (count_q),
    .raddr_i   (wbq.read_register_1),
    .hit_o     (wbq.fwd_hit_1),
    .data_o    (wbq.fwd_data_1)
  );

  regfile_fwd_match #(.DEPTH(DEPTH)) u_fwd_2 (
    .entries_i (entries),
    .head_i    (head_q),
    .count_i   (count_q),
    .raddr_i   (wbq.read_register_2),
    .hit_o     (wbq.fwd_hit_2),
    .data_o    (wbq.fwd_data_2)
  );

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Scoreboard bench for the writeback queue: randomized traffic against a queue-of-results model,
// plus a short directed run on a zero-register-discarding instance.
module tb_regfile_writeback_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } res_t;

  logic clk = 1'b0;
  logic rst_n0 = 1'b0;
  logic rst_n1 = 1'b0;

  always #5 clk = ~clk;

  regfile_writeback_queue_if #(.DEPTH(DEPTH)) bus0 ();
  regfile_writeback_queue_if #(.DEPTH(DEPTH)) bus1 ();

  regfile_writeback_queue #(.DEPTH(DEPTH), .ZERO_REG_EN(1'b0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n0),
    .wbq   (bus0)
  );

  regfile_writeback_queue #(.DEPTH(DEPTH), .ZERO_REG_EN(1'b1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n1),
    .wbq   (bus1)
  );

  res_t model_q[$];
  int   checks = 0;
  int   passes = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference forwarding: last (youngest) queued result with a matching destination.
  function automatic void fwd_ref(input logic [4:0] ra, output logic hit, output logic [63:0] dat);
    hit = 1'b0;
    dat = '0;
    foreach (model_q[i]) begin
      if (model_q[i].rd == ra) begin
        hit = 1'b1;
        dat = model_q[i].data;
      end
    end
  endfunction

  // One clock of stimulus on instance 0; accepted results are pushed to the scoreboard.
  task automatic step(input bit v, input logic [4:0] rd, input logic [63:0] d, input bit hold,
                      input logic [4:0] r1, input logic [4:0] r2, input bit rstn);
    bit   acc;
    res_t e;
    @(negedge clk);
    rst_n0               = rstn;
    bus0.in_valid        = v;
    bus0.in_rd           = rd;
    bus0.in_data         = d;
    bus0.wb_hold         = hold;
    bus0.read_register_1 = r1;
    bus0.read_register_2 = r2;
    #1;
    acc = rstn && v && (model_q.size() < DEPTH);
    @(posedge clk);
    if (!rstn) begin
      model_q.delete();
    end else if (acc) begin
      e.rd   = rd;
      e.data = d;
      model_q.push_back(e);
    end
  endtask

  // Monitor: compares all outputs to the model each cycle and retires the head when a write is due.
  initial begin
    int          exp_cnt;
    bit          exp_we;
    logic        h;
    logic [63:0] dat;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        exp_cnt = model_q.size();
        exp_we  = (exp_cnt != 0) && !bus0.wb_hold;
        chk("count",     64'(bus0.count),     64'(exp_cnt));
        chk("in_ready",  64'(bus0.in_ready),  64'(exp_cnt < DEPTH));
        chk("reg_write", 64'(bus0.reg_write), 64'(exp_we));
        if (exp_cnt != 0) begin
          chk("write_register", 64'(bus0.write_register), 64'(model_q[0].rd));
          chk("write_data",     bus0.write_data,          model_q[0].data);
        end else begin
          chk("write_register_idle", 64'(bus0.write_register), 64'd0);
          chk("write_data_idle",     bus0.write_data,          64'd0);
        end
        fwd_ref(bus0.read_register_1, h, dat);
        chk("fwd_hit_1",  64'(bus0.fwd_hit_1), 64'(h));
        chk("fwd_data_1", bus0.fwd_data_1,     dat);
        fwd_ref(bus0.read_register_2, h, dat);
        chk("fwd_hit_2",  64'(bus0.fwd_hit_2), 64'(h));
        chk("fwd_data_2", bus0.fwd_data_2,     dat);
        if (exp_we) void'(model_q.pop_front());
      end
    end
  end

  initial begin
    logic [4:0]  rd, r1, r2;
    logic [63:0] d;

    bus1.in_valid = 1'b0; bus1.in_rd = '0; bus1.in_data = '0; bus1.wb_hold = 1'b0;
    bus1.read_register_1 = '0; bus1.read_register_2 = '0;

    // Initial reset
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    mon_en = 1'b1;

    // Reset in the middle of buffering
    step(1, 5'd3, 64'hA, 1, 5'd3, 5'd4, 1);
    step(1, 5'd4, 64'hB, 1, 5'd3, 5'd4, 1);
    step(0, 0, 0, 1, 5'd3, 5'd4, 0);
    step(0, 0, 0, 1, 5'd3, 5'd4, 1);
    step(0, 0, 0, 0, 5'd3, 5'd4, 1);

    // Single write from empty
    step(1, 5'd5, 64'h1234, 0, 5'd5, 5'd0, 1);
    step(0, 0, 0, 0, 5'd5, 5'd0, 1);
    step(0, 0, 0, 0, 5'd5, 5'd0, 1);

    // Fill to full under hold, reject a fifth, then drain in order
    for (int i = 1; i <= 4; i++) step(1, 5'(i), 64'(i * 'h11), 1, 5'd2, 5'd4, 1);
    step(1, 5'd9, 64'h99, 1, 5'd9, 5'd1, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 5'd3, 5'd4, 1);

    // Forwarding priority between two results to the same register
    step(1, 5'd7, 64'h1, 1, 5'd7, 5'd8, 1);
    step(1, 5'd7, 64'h2, 1, 5'd7, 5'd8, 1);
    step(0, 0, 0, 1, 5'd7, 5'd8, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 5'd7, 5'd8, 1);

    // Steady push and pop with two entries in flight
    step(1, 5'd10, 64'hA0, 1, 5'd10, 5'd11, 1);
    step(1, 5'd11, 64'hB0, 1, 5'd10, 5'd11, 1);
    for (int i = 0; i < 6; i++) step(1, 5'(12 + i), 64'(16'hC000 + i), 0, 5'(12 + i), 5'd11, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 5'd0, 5'd0, 1);

    // Randomized traffic with occasional resets and zero-register targets
    for (int n = 0; n < 1500; n++) begin
      rd = ($urandom % 8 == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      r1 = ($urandom % 8 == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      r2 = 5'($urandom_range(0, 7));
      d  = {$urandom, $urandom};
      step(($urandom % 4) != 0, rd, d, ($urandom % 4) == 0, r1, r2, ($urandom % 200) != 0);
    end
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 5'd0, 5'd0, 1);
    mon_en = 1'b0;

    // Zero-register discard on the second instance
    @(negedge clk);
    rst_n1 = 1'b1;
    bus1.in_valid = 1'b1; bus1.in_rd = 5'd31; bus1.in_data = 64'hFF; bus1.read_register_1 = 5'd31;
    #2;
    chk("z_in_ready", 64'(bus1.in_ready), 64'd1);
    chk("z_count0",   64'(bus1.count),    64'd0);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    #2;
    chk("z_count1",  64'(bus1.count),     64'd0);
    chk("z_we1",     64'(bus1.reg_write), 64'd0);
    chk("z_fwd_hit", 64'(bus1.fwd_hit_1), 64'd0);
    @(negedge clk);
    bus1.in_valid = 1'b1; bus1.in_rd = 5'd30; bus1.in_data = 64'hAB;
    #2;
    chk("z_we2", 64'(bus1.reg_write), 64'd0);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    #2;
    chk("z_we3",    64'(bus1.reg_write),      64'd1);
    chk("z_wreg3",  64'(bus1.write_register), 64'd30);
    chk("z_wdata3", bus1.write_data,          64'hAB);
    chk("z_count3", 64'(bus1.count),          64'd1);
    @(negedge clk);
    #2;
    chk("z_we4",    64'(bus1.reg_write), 64'd0);
    chk("z_count4", 64'(bus1.count),     64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
